// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write port, two read ports, clear request and status.
// The master side drives requests; the register file sits on the slave side.
interface regfile_param_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;
  logic [DEPTH-1:0]  written;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, busy, wr_drop, written
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, busy, wr_drop, written
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational read ports,
// optional write bypass and hardwired-zero entry 0, per-entry written flags, clear-all sweep.
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input logic            clk,
  input logic            reset,
  regfile_param_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // DEPTH may equal 2^ADDR_W, so the range compare needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  written_q, written_d;
  logic              wr_drop_q, wr_drop_d;
  logic              wr_acc;
  logic [WIDTH-1:0]  rd_a, rd_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_X;
  endfunction

  function automatic logic is_zero_entry(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  always_comb begin
    wr_acc = bus.we && (state_q == ST_IDLE) && in_range(bus.waddr) &&
             !is_zero_entry(bus.waddr);
  end

  // Next-state logic for the clear FSM, storage array, flags and drop pulse.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    written_d = written_q;
    wr_drop_d = bus.we && !wr_acc;

    unique case (state_q)
      ST_IDLE: begin
        // A write arriving with clr_req still commits; the sweep zeroes it later.
        if (wr_acc) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (bus.waddr == ADDR_W'(i)) begin
              mem_d[i]     = bus.wdata;
              written_d[i] = 1'b1;
            end
          end
        end
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end

      ST_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ptr_q == ADDR_W'(i)) begin
            mem_d[i]     = '0;
            written_d[i] = 1'b0;
          end
        end
        // The pointer parks on the last entry instead of wrapping.
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      written_q <= '0;
      wr_drop_q <= 1'b0;
      // NOTE: the storage array is reset too, because every entry must read 0 right after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      written_q <= written_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
    end
  end

  // Read port A: out-of-range and hardwired-zero first, then bypass, then storage.
  always_comb begin
    rd_a = '0;
    if (in_range(bus.raddr_a) && !is_zero_entry(bus.raddr_a)) begin
      if (BYPASS && wr_acc && (bus.waddr == bus.raddr_a)) begin
        rd_a = bus.wdata;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.raddr_a == ADDR_W'(i)) begin
            rd_a = mem_q[i];
          end
        end
      end
    end
  end

  // Read port B: identical priority to port A.
  always_comb begin
    rd_b = '0;
    if (in_range(bus.raddr_b) && !is_zero_entry(bus.raddr_b)) begin
      if (BYPASS && wr_acc && (bus.waddr == bus.raddr_b)) begin
        rd_b = bus.wdata;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.raddr_b == ADDR_W'(i)) begin
            rd_b = mem_q[i];
          end
        end
      end
    end
  end

  assign bus.rdata_a = rd_a;
  assign bus.rdata_b = rd_b;
  assign bus.busy    = (state_q == ST_CLEAR);
  assign bus.wr_drop = wr_drop_q;
  assign bus.written = written_q;

endmodule

// File: tb/tb_regfile_param.sv
// Drives four regfile_param variants (default, no bypass, zero entry, depth 3) with shared
// stimulus and compares every output against a behavioural model of the register file.
module tb_regfile_param;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic       clr_req;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_seen;

  int cfg_depth  [4] = '{4, 4, 4, 3};
  bit cfg_bypass [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_zero   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [7:0] m_mem  [4][4];
  logic [3:0] m_wr   [4];
  bit         m_act  [4];
  int         m_idx  [4];
  bit         m_drop [4];

  logic [7:0] obs_a    [4];
  logic [7:0] obs_b    [4];
  logic       obs_busy [4];
  logic       obs_drop [4];
  logic [3:0] obs_w    [4];

  regfile_param_if #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) if0 ();
  regfile_param_if #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) if1 ();
  regfile_param_if #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) if2 ();
  regfile_param_if #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) if3 ();

  regfile_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG(1'b0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  regfile_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b0), .ZERO_REG(1'b0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  regfile_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  regfile_param #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG(1'b0))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.we = we;  assign if0.waddr = waddr;  assign if0.wdata = wdata;
  assign if0.raddr_a = raddr_a;  assign if0.raddr_b = raddr_b;  assign if0.clr_req = clr_req;
  assign if1.we = we;  assign if1.waddr = waddr;  assign if1.wdata = wdata;
  assign if1.raddr_a = raddr_a;  assign if1.raddr_b = raddr_b;  assign if1.clr_req = clr_req;
  assign if2.we = we;  assign if2.waddr = waddr;  assign if2.wdata = wdata;
  assign if2.raddr_a = raddr_a;  assign if2.raddr_b = raddr_b;  assign if2.clr_req = clr_req;
  assign if3.we = we;  assign if3.waddr = waddr;  assign if3.wdata = wdata;
  assign if3.raddr_a = raddr_a;  assign if3.raddr_b = raddr_b;  assign if3.clr_req = clr_req;

  assign obs_a[0] = if0.rdata_a;  assign obs_b[0] = if0.rdata_b;
  assign obs_a[1] = if1.rdata_a;  assign obs_b[1] = if1.rdata_b;
  assign obs_a[2] = if2.rdata_a;  assign obs_b[2] = if2.rdata_b;
  assign obs_a[3] = if3.rdata_a;  assign obs_b[3] = if3.rdata_b;
  assign obs_busy[0] = if0.busy;  assign obs_drop[0] = if0.wr_drop;
  assign obs_busy[1] = if1.busy;  assign obs_drop[1] = if1.wr_drop;
  assign obs_busy[2] = if2.busy;  assign obs_drop[2] = if2.wr_drop;
  assign obs_busy[3] = if3.busy;  assign obs_drop[3] = if3.wr_drop;
  assign obs_w[0] = if0.written;
  assign obs_w[1] = if1.written;
  assign obs_w[2] = if2.written;
  assign obs_w[3] = {1'b0, if3.written};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit m_accept(input int k);
    return we && !m_act[k] && (int'(waddr) < cfg_depth[k]) && !(cfg_zero[k] && waddr == 2'd0);
  endfunction

  function automatic logic [7:0] m_read(input int k, input logic [1:0] ra);
    if (int'(ra) >= cfg_depth[k]) return 8'h00;
    if (cfg_zero[k] && ra == 2'd0) return 8'h00;
    if (cfg_bypass[k] && m_accept(k) && waddr == ra) return wdata;
    return m_mem[k][ra];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 4; e++) m_mem[k][e] = 8'h00;
      m_wr[k] = 4'h0;  m_act[k] = 1'b0;  m_idx[k] = 0;  m_drop[k] = 1'b0;
    end
  endtask

  task automatic m_update();
    for (int k = 0; k < 4; k++) begin
      bit acc;
      acc = m_accept(k);
      m_drop[k] = we && !acc;
      if (m_act[k]) begin
        m_mem[k][m_idx[k]] = 8'h00;
        m_wr[k][m_idx[k]]  = 1'b0;
        m_idx[k]++;
        if (m_idx[k] == cfg_depth[k]) m_act[k] = 1'b0;
      end else begin
        if (acc) begin
          m_mem[k][waddr] = wdata;
          m_wr[k][waddr]  = 1'b1;
        end
        if (clr_req) begin
          m_act[k] = 1'b1;
          m_idx[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s/u%0d/rdata_a", tag, k), 32'(obs_a[k]), 32'(m_read(k, raddr_a)));
      check($sformatf("%s/u%0d/rdata_b", tag, k), 32'(obs_b[k]), 32'(m_read(k, raddr_b)));
      check($sformatf("%s/u%0d/busy", tag, k), 32'(obs_busy[k]), 32'(m_act[k]));
      check($sformatf("%s/u%0d/wr_drop", tag, k), 32'(obs_drop[k]), 32'(m_drop[k]));
      check($sformatf("%s/u%0d/written", tag, k), 32'(obs_w[k]), 32'(m_wr[k]));
    end
  endtask

  // Apply inputs just after the falling edge and check the pre-edge view.
  task automatic drive(input string tag, input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic c);
    we = w;  waddr = wa;  wdata = wd;  raddr_a = ra;  raddr_b = rb;  clr_req = c;
    #1;
    check_all(tag);
  endtask

  task automatic tick();
    if (obs_busy[0]) busy_seen++;
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] a2;
    logic [1:0] b2;
    logic [7:0] d8;

    busy_seen = 0;
    m_reset();
    reset = 1'b1;
    we = 1'b0;  waddr = 2'd0;  wdata = 8'h00;  raddr_a = 2'd0;  raddr_b = 2'd1;  clr_req = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fill 0..3 and read back.
    drive("fill0", 1'b1, 2'd0, 8'h11, 2'd2, 2'd3, 1'b0);  tick();
    drive("fill1", 1'b1, 2'd1, 8'h22, 2'd2, 2'd3, 1'b0);  tick();
    drive("fill2", 1'b1, 2'd2, 8'h33, 2'd2, 2'd3, 1'b0);  tick();
    drive("fill3", 1'b1, 2'd3, 8'h44, 2'd2, 2'd3, 1'b0);  tick();
    drive("read23", 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0);
    check("fill_rdata_a", 32'(obs_a[0]), 32'h33);
    check("fill_rdata_b", 32'(obs_b[0]), 32'h44);
    check("fill_written", 32'(obs_w[0]), 32'hF);
    tick();

    // Same-cycle bypass versus registered-only read.
    drive("bypass", 1'b1, 2'd1, 8'hA5, 2'd1, 2'd0, 1'b0);
    check("bypass_on", 32'(obs_a[0]), 32'hA5);
    check("bypass_off_old", 32'(obs_a[1]), 32'h22);
    tick();
    drive("bypass_after", 1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 1'b0);
    check("bypass_off_new", 32'(obs_a[1]), 32'hA5);
    tick();

    // Hardwired-zero entry rejects the write.
    drive("zero_wr", 1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 1'b0);  tick();
    drive("zero_rd", 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
    check("zero_drop", 32'(obs_drop[2]), 32'h1);
    check("zero_rdata", 32'(obs_a[2]), 32'h0);
    check("zero_written0", 32'(obs_w[2][0]), 32'h0);
    tick();
    drive("zero_idle", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0);
    check("zero_drop_end", 32'(obs_drop[2]), 32'h0);
    tick();

    // Out-of-range address on the depth-3 variant.
    drive("oor_wr", 1'b1, 2'd3, 8'h77, 2'd3, 2'd2, 1'b0);  tick();
    drive("oor_rd", 1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 1'b0);
    check("oor_drop", 32'(obs_drop[3]), 32'h1);
    check("oor_rdata", 32'(obs_a[3]), 32'h0);
    tick();

    // Refill, then sweep with a dropped write and an ignored second clear.
    for (int i = 0; i < 4; i++) begin
      a2 = 2'(i);
      d8 = 8'(8'hC0 + i);
      drive("refill", 1'b1, a2, d8, a2, 2'd0, 1'b0);
      tick();
    end
    busy_seen = 0;
    drive("clr_req", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b1);  tick();
    for (int i = 0; i < 6; i++) begin
      a2 = 2'(i);
      b2 = 2'(i - 1);
      drive("sweep", (i == 0), 2'd2, 8'hEE, a2, b2, (i == 1));
      if (i == 1) check("sweep_drop", 32'(obs_drop[0]), 32'h1);
      tick();
    end
    check("busy_cycles", 32'(busy_seen), 32'd4);
    check("sweep_written", 32'(obs_w[0]), 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      drive("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
      tick();
    end

    // Asynchronous reset in the middle of a sweep and between clock edges.
    for (int i = 0; i < 4; i++) begin
      a2 = 2'(i);
      drive("prefill", 1'b1, a2, 8'h5A ^ 8'(i), a2, 2'd3, 1'b0);
      tick();
    end
    drive("clr_mid", 1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b1);  tick();
    drive("clr_run", 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0);  tick();
    #1;
    reset = 1'b1;
    m_reset();
    #1;
    check_all("rst_mid");
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i);
      raddr_b = 2'(3 - i);
      #1;
      check_all("rst_scan");
    end
    @(negedge clk);
    reset = 1'b0;
    drive("post_rst_wr", 1'b1, 2'd1, 8'h3C, 2'd1, 2'd2, 1'b0);  tick();
    drive("post_rst_rd", 1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b0);
    check("post_rst_data", 32'(obs_a[1]), 32'h3C);
    check("post_rst_written", 32'(obs_w[1]), 32'h2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the team's 4x8 register file.
- Provides DEPTH entries of WIDTH bits with one synchronous write port and two combinational read ports.
- Adds optional write-to-read bypass, an optional hardwired-zero entry 0, per-entry "written" flags and a sequential clear-all engine.
- Sits between the datapath ALU/controller and operand muxes in lab CPU designs.

Parameters:
- WIDTH, 8, data width of each entry.
- DEPTH, 4, number of entries; must be 2 or more and at most 2^ADDR_W.
- ADDR_W, 2, address width.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  WIDTH  read port A data (combinational).
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  WIDTH  read port B data (combinational).
- clr_req  input  1  single-cycle request to clear all entries.
- busy  output  1  high while the clear engine runs.
- wr_drop  output  1  one-cycle pulse when a write is rejected.
- written  output  DEPTH  bit i is set when entry i holds a write since the last reset or clear.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all entries = 0, written = 0, busy = 0, wr_drop = 0;
  - FSM = IDLE, clear pointer = 0.
  - Reset asserted mid-clear aborts the clear.
- Write, accepted when all of the following hold at a rising edge:
  - we = 1;
  - FSM = IDLE;
  - waddr < DEPTH;
  - not (ZERO_REG = 1 and waddr = 0).
  - An accepted write stores wdata into entry waddr and sets written[waddr]. Visible on the reads one cycle later, or the same cycle via bypass.
- Write drop: when we = 1 but the write is rejected (FSM = CLEAR, waddr >= DEPTH, or the ZERO_REG entry 0), wr_drop = 1 on the following cycle, then 0. wr_drop is registered.
- Read, per port, evaluated purely combinationally in priority order:
  1. raddr >= DEPTH -> 0.
  2. ZERO_REG = 1 and raddr = 0 -> 0.
  3. BYPASS = 1, an accepted write this cycle, and waddr = raddr -> wdata.
  4. Otherwise -> stored entry.
  - Both ports may address the same entry.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req = 1 -> CLEAR, pointer = 0, busy = 1 from the next cycle.
  - A write accepted in the same cycle as clr_req still commits; the sweep later zeroes it.
  - CLEAR: each cycle, entry[pointer] = 0, written[pointer] = 0, pointer += 1.
  - After clearing entry DEPTH-1 -> IDLE, busy = 0. busy is high for exactly DEPTH cycles.
  - clr_req during CLEAR is ignored; it is not queued.
  - Reads during CLEAR return current contents, so a partially cleared state is visible. Bypass never applies because no write is accepted in CLEAR.
- Width and arithmetic: the pointer is ADDR_W bits and never wraps past DEPTH-1; it returns to 0 on entering CLEAR.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33, 0x44 to addresses 0-3; read A = 2, B = 3 -> 0x33 / 0x44; written = 4'b1111.
- BYPASS = 1: we = 1, waddr = 1, wdata = 0xA5, raddr_a = 1 in the same cycle -> rdata_a = 0xA5 combinationally, before the edge. BYPASS = 0: old value is returned until after the edge.
- ZERO_REG = 1: write 0xFF to address 0 -> wr_drop pulses 1 cycle; rdata = 0; written[0] = 0.
- DEPTH = 3, ADDR_W = 2: write to address 3 -> wr_drop pulse; read address 3 -> 0.
- Fill all entries, pulse clr_req -> busy high exactly 4 cycles; entries read 0 one by one in order 0..3; written = 0.
  - A write issued during busy -> dropped, wr_drop pulses.
  - A second clr_req mid-sweep has no effect.
- Assert reset asynchronously mid-clear and mid-clock -> busy = 0, all entries 0 immediately; the next write succeeds normally.
